// File: rtl/envelope_scheduler.sv
// Envelope scheduler: owns the tone-generator register write port and merges host
// writes with per-channel envelope level updates under round-robin arbitration.
module envelope_scheduler #(
    parameter int         TICK_DIV = 1024,
    parameter logic [3:0] PEAK     = 4'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_req,
    input  logic [2:0] host_addr,
    input  logic [4:0] host_data,
    output logic       host_ack,
    input  logic       trig_a,
    input  logic       trig_b,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic [3:0] env_level_a,
    output logic [3:0] env_level_b
);
    typedef enum logic [1:0] {SrcH = 2'd0, SrcA = 2'd1, SrcB = 2'd2} srcT;

    typedef struct packed {
        logic [3:0] lvl;
        logic       pnd;
    } chanT;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [2:0]  ADDR_A    = 3'd2;
    localparam logic [2:0]  ADDR_B    = 3'd3;
    localparam logic [2:0]  ADDR_EN   = 3'd6;

    logic [15:0] prescaleCnt;
    logic        tick;
    logic [1:0]  envEn;
    chanT        chA, chB;
    srcT         lastGrant;
    logic        hostEligible;
    logic [2:0]  reqVec, grantVec;

    function automatic logic [3:0] decLevel(input logic [3:0] lvl);
        return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
    endfunction

    // One-hot grant {B, A, H}; search begins at the source after the last grant.
    function automatic logic [2:0] rrPick(input srcT last, input logic [2:0] req);
        logic [2:0] g;
        case (last)
            SrcH:    g = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            SrcA:    g = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: g = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
        return g;
    endfunction

    // Per-channel priority: trigger, then host level load, then tick decay.
    // A same-cycle set of pending always beats the clear from its own grant.
    function automatic chanT chanNext(
        input chanT       cur,
        input logic       trig,
        input logic       en,
        input logic       hostLoad,
        input logic [3:0] hostLvl,
        input logic       tk,
        input logic       granted
    );
        chanT n;
        n = cur;
        if (trig && en) begin
            n.lvl = PEAK;
            n.pnd = 1'b1;
        end else if (hostLoad) begin
            n.lvl = hostLvl;
            n.pnd = 1'b0;
        end else if (tk && en && cur.lvl != 4'd0) begin
            n.lvl = decLevel(cur.lvl);
            n.pnd = 1'b1;
        end else if (granted) begin
            n.pnd = 1'b0;
        end
        return n;
    endfunction

    assign tick         = (prescaleCnt == TICK_LAST);
    // The ack cycle masks a still-held request so one host write is granted once.
    assign hostEligible = host_req && !host_ack;
    assign reqVec       = {chB.pnd, chA.pnd, hostEligible};
    assign grantVec     = rrPick(lastGrant, reqVec);
    assign env_level_a  = chA.lvl;
    assign env_level_b  = chB.lvl;

    // Grant stage: decision above, registered write port and channel state below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaleCnt  <= '0;
            envEn        <= '0;
            lastGrant    <= SrcB;
            host_ack     <= 1'b0;
            write_strobe <= 1'b0;
            address      <= '0;
            data         <= '0;
            chA          <= '0;
            chB          <= '0;
        end else begin
            prescaleCnt  <= tick ? '0 : prescaleCnt + 16'd1;
            host_ack     <= grantVec[0];
            write_strobe <= 1'b0;
            chA <= chanNext(chA, trig_a, envEn[0], grantVec[0] && host_addr == ADDR_A,
                            host_data[3:0], tick, grantVec[1]);
            chB <= chanNext(chB, trig_b, envEn[1], grantVec[0] && host_addr == ADDR_B,
                            host_data[3:0], tick, grantVec[2]);
            if (grantVec[0]) begin
                lastGrant <= SrcH;
                if (host_addr <= 3'd5) begin
                    write_strobe <= 1'b1;
                    address      <= host_addr;
                    data         <= host_data;
                end else if (host_addr == ADDR_EN) begin
                    envEn <= host_data[1:0];
                end
            end else if (grantVec[1]) begin
                lastGrant    <= SrcA;
                write_strobe <= 1'b1;
                address      <= ADDR_A;
                data         <= {1'b0, chA.lvl};
            end else if (grantVec[2]) begin
                lastGrant    <= SrcB;
                write_strobe <= 1'b1;
                address      <= ADDR_B;
                data         <= {1'b0, chB.lvl};
            end
        end
    end
endmodule

// File: doc/envelope_scheduler.md
ENVELOPE_SCHEDULER -- requirements
Module: envelope_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 1024: clock cycles per envelope decay step, legal range 2..65535.
REQ-002 Parameter PEAK, default 15: 4-bit level loaded on trigger.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 host_req  input  1  host write request; held until host_ack.
REQ-006 host_addr  input  3  host register address, same map as the generator write port.
REQ-007 host_data  input  5  host write data.
REQ-008 host_ack  output  1  one-cycle pulse: host request accepted.
REQ-009 trig_a, trig_b  input  1 each  note-on trigger for tone channel A / B.
REQ-010 write_strobe  output  1  one-cycle write pulse to the generator.
REQ-011 address  output  3  generator register address.
REQ-012 data  output  5  generator write data.
REQ-013 env_level_a, env_level_b  output  4 each  current envelope level per channel.

Function
REQ-014 Block is the sole master of the generator write port; at most one write per cycle.
REQ-015 Three sources: H (host request), A (channel-A pending), B (channel-B pending).
REQ-016 Arbitration round-robin over H->A->B->H; search starts at source after last granted; reset pointer: H searched first.
REQ-017 Grant decided in cycle N; write_strobe/address/data registered, valid in cycle N+1 only; write_strobe low in all other cycles.
REQ-018 host_ack pulses in cycle N+1 of an H grant; req still high in cycle N+1 is not re-granted; req high in N+2 is a new request.
REQ-019 A grant drives address 3'd2, data {1'b0, env_level_a}; B grant drives address 3'd3, data {1'b0, env_level_b}; value sampled at grant cycle.
REQ-020 Host address 0..5 forwarded unchanged; address 6 writes env_en[1:0] <= host_data[1:0] (bit0 = A, bit1 = B), acked, no strobe; address 7 acked, discarded, no strobe.
REQ-021 Granted host write to address 2 (3) loads env_level_a (_b) <= host_data[3:0] and clears pending A (B).
REQ-022 Prescaler counts 0..TICK_DIV-1, wraps; tick = one cycle at count TICK_DIV-1.
REQ-023 On tick, each channel with env_en set and level > 0 decrements by 1 and sets its pending; level 0 holds, no pending set.
REQ-024 trig_x with env_en[x] set loads level <= PEAK and sets pending; trig_x with env_en[x] clear is ignored.
REQ-025 Same-cycle priority per channel: trigger > host level load > tick decrement; pending set if trigger or tick wins.
REQ-026 Pending coalesces: updates before grant overwrite level; single write carries latest level.
REQ-027 Pending cleared on own grant unless same-cycle trigger/tick sets it again (set wins).
REQ-028 Worst case latency from pending set to strobe: 3 cycles.

Reset
REQ-029 With rst_n low at a clock edge: write_strobe 0, address 0, data 0, host_ack 0, env_level_a/b 0, env_en 0, pending 0, prescaler 0, RR pointer to H.
REQ-030 Reset mid-operation discards pending and in-flight grants; no strobe or ack in cycle after reset edge.

Verification
REQ-031 Reset, host writes addr 0 data 5'h0A -> strobe cycle N+1 addr 0 data 0x0A, host_ack same cycle, exactly one strobe.
REQ-032 TICK_DIV=4, env_en=3, trig_a -> strobe addr 2 data 15; then every 4 cycles strobes 14,13..0, then no strobes.
REQ-033 host_req held high, A and B pending simultaneously -> grants ordered H, A, B, H, each strobe one cycle.
REQ-034 trig_a same cycle as tick and granted host write addr 2 data 3 -> env_level_a = 15, pending A remains, next A write data 15.
REQ-035 Host addr 6 data 0, then trig_a/trig_b -> no strobes, levels unchanged; addr 7 -> host_ack only.
REQ-036 rst_n low during pending A and active host request -> next cycle all outputs 0, no ack, no strobe.
